// File: rtl/f1_conv_rd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// f1_conv_rd_ctrl_pkg
// Shared definitions for the conv-layer-1 feature RAM read sequencer:
// default geometry, RAM timing, FSM state encoding, the per-pixel window tag
// and a helper that computes the output-map dimension.
// -----------------------------------------------------------------------------
package f1_conv_rd_ctrl_pkg;

    localparam int unsigned F1_IMG_W      = 32;
    localparam int unsigned F1_IMG_H      = 32;
    localparam int unsigned F1_K          = 5;
    localparam int unsigned F1_ADDR_W     = 10;
    localparam int unsigned PIX_W         = 8;
    localparam int unsigned BRAM_RD_LAT   = 2;
    localparam int unsigned F1_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } rd_state_e;

    // Window-boundary tag carried alongside each RAM read.
    typedef struct packed {
        logic frame_last;
        logic last;
        logic first;
    } pix_tag_t;

    localparam int unsigned TagW = $bits(pix_tag_t);

    // Valid-convolution output dimension.
    function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
        return img - k + 1;
    endfunction

endpackage

// File: rtl/f1_conv_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// f1_conv_rd_ctrl_if
// Bundles the sequencer's control, RAM read port and pixel stream.
//   start/busy/done            frame control
//   ram_rd_en/raddr/rdata      RAM read port (rdata valid RD_LAT cycles later)
//   pix_valid/ready/data/first/last/frame_last   output pixel stream
// master: the sequencer.  slave: the environment (RAM, MAC array, host).
// -----------------------------------------------------------------------------
interface f1_conv_rd_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              pix_first;
    logic              pix_last;
    logic              frame_last;

    modport master (
        input  start, ram_rdata, pix_ready,
        output busy, done, ram_rd_en, ram_raddr,
        output pix_valid, pix_data, pix_first, pix_last, frame_last
    );

    modport slave (
        output start, ram_rdata, pix_ready,
        input  busy, done, ram_rd_en, ram_raddr,
        input  pix_valid, pix_data, pix_first, pix_last, frame_last
    );
endinterface

// File: rtl/f1_tag_fifo.sv
// -----------------------------------------------------------------------------
// f1_tag_fifo
// Synchronous FIFO holding tagged pixels {frame_last, last, first, data}.
//   clk, rst_n     clock, asynchronous active-low reset (empties FIFO, zeroes RAM)
//   wr_en_i/data_i push
//   rd_en_i        pop (head is rd_data_o; ignored when empty)
//   empty_o        no entries
//   count_o        occupancy 0..Depth
// Simultaneous push and pop both take effect; occupancy is unchanged.
// Depth must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module f1_tag_fifo #(
    parameter int unsigned Width = 11,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [Width-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    // The upstream credit scheme never writes when full; the gate is belt-and-braces.
    assign do_wr = wr_en_i && !full;
    assign do_rd = rd_en_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = empty;
    assign count_o   = count_q;

endmodule

// File: rtl/f1_conv_rd_ctrl.sv
// -----------------------------------------------------------------------------
// f1_conv_rd_ctrl
// Read-side sequencer for the conv-1 feature RAM. On start it walks every KxK
// window of the IMG_H x IMG_W map (loop nest innermost first: kc, kr, ocol,
// orow), issues one RAM read per window pixel and streams the returned pixels
// in order, tagged with window first/last and frame_last.
//   clk, rst_n   single clock, asynchronous active-low reset
//   bus          f1_conv_rd_ctrl_if master: start/busy/done, RAM read port,
//                pixel valid/ready stream
// Reads are issued only while reads in flight plus buffered pixels are below
// FIFO_DEPTH, so every returning datum is guaranteed a FIFO slot.
// -----------------------------------------------------------------------------
module f1_conv_rd_ctrl
    import f1_conv_rd_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W      = F1_IMG_W,
    parameter int unsigned IMG_H      = F1_IMG_H,
    parameter int unsigned K          = F1_K,
    parameter int unsigned ADDR_W     = F1_ADDR_W,
    parameter int unsigned DATA_W     = PIX_W,
    parameter int unsigned RD_LAT     = BRAM_RD_LAT,
    parameter int unsigned FIFO_DEPTH = F1_FIFO_DEPTH
) (
    input logic               clk,
    input logic               rst_n,
    f1_conv_rd_ctrl_if.master bus
);
    localparam int unsigned OutW  = out_dim(IMG_W, K);
    localparam int unsigned OutH  = out_dim(IMG_H, K);
    localparam int unsigned KW    = $clog2(K + 1);
    localparam int unsigned OcW   = $clog2(OutW + 1);
    localparam int unsigned OrW   = $clog2(OutH + 1);
    localparam int unsigned InflW = $clog2(RD_LAT + 1);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FifoW = DATA_W + TagW;

    rd_state_e            state_q, state_d;
    logic [KW-1:0]        kc_q, kc_d;
    logic [KW-1:0]        kr_q, kr_d;
    logic [OcW-1:0]       ocol_q, ocol_d;
    logic [OrW-1:0]       orow_q, orow_d;
    logic [RD_LAT-1:0]    tv_q, tv_d;
    pix_tag_t [RD_LAT-1:0] tg_q, tg_d;

    logic [InflW-1:0]     in_flight;
    logic [CntW-1:0]      fifo_count;
    logic                 fifo_empty;
    logic                 fifo_wr;
    logic [FifoW-1:0]     fifo_wdata;
    logic [FifoW-1:0]     fifo_rdata;
    pix_tag_t             head_tag;
    pix_tag_t             issue_tag;
    logic                 issue;
    logic                 pop;
    logic                 done;
    logic                 kc_end, kr_end, ocol_end, orow_end;

    assign kc_end   = (kc_q == KW'(K - 1));
    assign kr_end   = (kr_q == KW'(K - 1));
    assign ocol_end = (ocol_q == OcW'(OutW - 1));
    assign orow_end = (orow_q == OrW'(OutH - 1));

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + InflW'(tv_q[i]);
        end
    end

    assign issue = (state_q == StRun) &&
                   ((32'(in_flight) + 32'(fifo_count)) < FIFO_DEPTH);

    assign issue_tag.first      = (kc_q == '0) && (kr_q == '0);
    assign issue_tag.last       = kc_end && kr_end;
    assign issue_tag.frame_last = kc_end && kr_end && ocol_end && orow_end;

    // Final pixel of the frame leaves the stream on this handshake.
    assign pop  = !fifo_empty && bus.pix_ready;
    assign done = pop && head_tag.frame_last;

    // Window counters and FSM next state.
    always_comb begin
        kc_d    = kc_q;
        kr_d    = kr_q;
        ocol_d  = ocol_q;
        orow_d  = orow_q;
        state_d = state_q;

        if (issue) begin
            kc_d = kc_q + KW'(1);
            if (kc_end) begin
                kc_d = '0;
                kr_d = kr_q + KW'(1);
                if (kr_end) begin
                    kr_d   = '0;
                    ocol_d = ocol_q + OcW'(1);
                    if (ocol_end) begin
                        ocol_d = '0;
                        orow_d = orow_end ? '0 : orow_q + OrW'(1);
                    end
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (issue && issue_tag.frame_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (done || (fifo_empty && (in_flight == '0))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tag pipe: stage RD_LAT-1 lines up with ram_rdata of the matching read.
    always_comb begin
        tv_d    = '0;
        tg_d    = '0;
        tv_d[0] = issue;
        tg_d[0] = issue ? issue_tag : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            tv_d[i] = tv_q[i-1];
            tg_d[i] = tg_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            kc_q    <= '0;
            kr_q    <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
            tv_q    <= '0;
            tg_q    <= '0;
        end else begin
            state_q <= state_d;
            kc_q    <= kc_d;
            kr_q    <= kr_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
            tv_q    <= tv_d;
            tg_q    <= tg_d;
        end
    end

    // RAM data is captured only when its tag emerges from the pipe.
    assign fifo_wr    = tv_q[RD_LAT-1];
    assign fifo_wdata = {tg_q[RD_LAT-1], bus.ram_rdata};

    f1_tag_fifo #(
        .Width (FifoW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign head_tag = pix_tag_t'(fifo_rdata[DATA_W +: TagW]);

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done;
    assign bus.ram_rd_en  = issue;
    assign bus.ram_raddr  = ADDR_W'((32'(orow_q) + 32'(kr_q)) * IMG_W
                                    + 32'(ocol_q) + 32'(kc_q));
    assign bus.pix_valid  = !fifo_empty;
    assign bus.pix_data   = fifo_rdata[DATA_W-1:0];
    assign bus.pix_first  = !fifo_empty && head_tag.first;
    assign bus.pix_last   = !fifo_empty && head_tag.last;
    assign bus.frame_last = !fifo_empty && head_tag.frame_last;

endmodule

// File: tb/tb_f1_conv_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_f1_conv_rd_ctrl
// Directed bench for f1_conv_rd_ctrl at default geometry. A golden window walk
// fills a scoreboard queue at each start; every pixel handshake pops and
// compares it. RAM model: 1024x8, two-cycle latency, mem[a] = a[7:0], and
// junk (8'hA5) on cycles without a read so stray sampling shows up.
// -----------------------------------------------------------------------------
module tb_f1_conv_rd_ctrl;

    localparam int IMG   = 32;
    localparam int KK    = 5;
    localparam int OUT   = IMG - KK + 1;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
        logic       fl;
    } pix_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    f1_conv_rd_ctrl_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    f1_conv_rd_ctrl #(
        .IMG_W      (IMG),
        .IMG_H      (IMG),
        .K          (KK),
        .ADDR_W     (10),
        .DATA_W     (8),
        .RD_LAT     (2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] ram_s1, ram_s2;
    always @(posedge clk) begin
        ram_s1 <= bus.ram_rd_en ? bus.ram_raddr[7:0] : 8'hA5;
        ram_s2 <= ram_s1;
    end
    assign bus.ram_rdata = ram_s2;

    pix_t       sb[$];
    int         vectors = 0;
    int         fails   = 0;
    int         issued  = 0;
    int         popped  = 0;
    int         done_cnt = 0;
    int         pop_seq = 0;
    int         iss_n   = 0;
    int         rdy_mode = 1;
    logic [9:0] iss_log [16];
    pix_t       p0, p24, p25, plast, held;
    logic       done_prev = 1'b0;
    logic       hold_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        pix_t e;
        int   a;
        for (int orow = 0; orow < OUT; orow++)
            for (int ocol = 0; ocol < OUT; ocol++)
                for (int kr = 0; kr < KK; kr++)
                    for (int kc = 0; kc < KK; kc++) begin
                        a    = (orow + kr) * IMG + ocol + kc;
                        e.d  = a[7:0];
                        e.f  = (kr == 0) && (kc == 0);
                        e.l  = (kr == KK - 1) && (kc == KK - 1);
                        e.fl = e.l && (orow == OUT - 1) && (ocol == OUT - 1);
                        sb.push_back(e);
                    end
    endtask

    // One clock: monitor at the falling edge, then drive after the rising edge.
    task automatic tick();
        pix_t got, e;
        logic hs;
        @(negedge clk);
        hs  = bus.pix_valid && bus.pix_ready;
        got = {bus.pix_data, bus.pix_first, bus.pix_last, bus.frame_last};
        if (bus.ram_rd_en) begin
            if (iss_n < 16) iss_log[iss_n] = bus.ram_raddr;
            iss_n++;
            issued++;
        end
        if (hold_prev && bus.pix_valid) chk("hold_stable", 32'(got), 32'(held));
        hold_prev = bus.pix_valid && !bus.pix_ready;
        held      = got;
        if (dut.fifo_wr) chk("write_while_full", 32'(dut.u_fifo.full), 0);
        if (done_prev) chk("busy_after_done", 32'(bus.busy), 0);
        if (hs) begin
            chk("sb_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pixel", 32'(got), 32'(e));
                chk("done_on_pop", 32'(bus.done), 32'(e.fl));
                if (e.fl) chk("busy_at_done", 32'(bus.busy), 1);
            end
            if (pop_seq == 0)  p0  = got;
            if (pop_seq == 24) p24 = got;
            if (pop_seq == 25) p25 = got;
            plast = got;
            pop_seq++;
            popped++;
        end else begin
            chk("done_idle", 32'(bus.done), 0);
        end
        if (bus.done) done_cnt++;
        done_prev = bus.done;
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.pix_ready = 1'b0;
            1:       bus.pix_ready = 1'b1;
            default: bus.pix_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},       32'(bus.busy), 0);
        chk({tag, "_done"},       32'(bus.done), 0);
        chk({tag, "_rd_en"},      32'(bus.ram_rd_en), 0);
        chk({tag, "_raddr"},      32'(bus.ram_raddr), 0);
        chk({tag, "_pix_valid"},  32'(bus.pix_valid), 0);
        chk({tag, "_pix_first"},  32'(bus.pix_first), 0);
        chk({tag, "_pix_last"},   32'(bus.pix_last), 0);
        chk({tag, "_frame_last"}, 32'(bus.frame_last), 0);
        chk({tag, "_pix_data"},   32'(bus.pix_data), 0);
    endtask

    task automatic check_first_issues(input string tag);
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < KK; kc++)
                chk(tag, 32'(iss_log[kr * KK + kc]), 32'(kr * IMG + kc));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        int dc0, is0, pm0, im0;
        bus.start     = 1'b0;
        bus.pix_ready = 1'b0;

        #12;
        check_reset_outputs("por");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("idle");

        // Full frame, always ready: issue order, window tags, done/busy.
        rdy_mode = 1;
        push_frame();
        iss_n = 0; pop_seq = 0; dc0 = done_cnt;
        pulse_start();
        chk("busy_after_start", 32'(bus.busy), 1);
        for (int i = 0; i < 25000 && done_cnt == dc0; i++) tick();
        chk("f1_done_count", 32'(done_cnt - dc0), 1);
        chk("f1_sb_drained", 32'(sb.size()), 0);
        chk("f1_pixels", 32'(pop_seq), OUT * OUT * KK * KK);
        check_first_issues("f1_issue_addr");
        chk("f1_first_pixel", 32'(p0), 32'({8'h00, 1'b1, 1'b0, 1'b0}));
        chk("f1_pix25_last",  32'(p24), 32'({8'h84, 1'b0, 1'b1, 1'b0}));
        chk("f1_win01_start", 32'(p25), 32'({8'h01, 1'b1, 1'b0, 1'b0}));
        chk("f1_final_pixel", 32'(plast), 32'({8'hFF, 1'b0, 1'b1, 1'b1}));
        for (int i = 0; i < 5; i++) tick();
        chk("f1_done_once", 32'(done_cnt - dc0), 1);
        chk("f1_idle_busy", 32'(bus.busy), 0);

        // Stall, then random ready with a stray start mid-frame.
        push_frame();
        pop_seq = 0; dc0 = done_cnt; im0 = issued; pm0 = popped;
        pulse_start();
        for (int i = 0; i < 9; i++) tick();
        rdy_mode = 0;
        for (int i = 0; i < 20; i++) tick();
        is0 = issued;
        for (int i = 0; i < 30; i++) tick();
        chk("stall_no_issue", 32'(issued - is0), 0);
        chk("stall_buffered", 32'((issued - im0) - (popped - pm0)), DEPTH);
        chk("stall_valid", 32'(bus.pix_valid), 1);
        rdy_mode = 2;
        for (int i = 0; i < 20000 && pop_seq < 6000; i++) tick();
        pulse_start();
        chk("restart_ignored_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 60000 && done_cnt == dc0; i++) tick();
        chk("f2_done_count", 32'(done_cnt - dc0), 1);
        chk("f2_sb_drained", 32'(sb.size()), 0);
        chk("f2_pixels", 32'(pop_seq), OUT * OUT * KK * KK);
        tick();
        chk("f2_idle_busy", 32'(bus.busy), 0);

        // Reset mid-frame, then a fresh frame from address 0.
        rdy_mode = 1;
        push_frame();
        pop_seq = 0;
        pulse_start();
        for (int i = 0; i < 8000 && pop_seq < 5000; i++) tick();
        chk("f3_reached_5000", 32'(pop_seq >= 5000), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        is0 = issued; pm0 = popped;
        for (int i = 0; i < 5; i++) tick();
        check_reset_outputs("postrst");
        chk("postrst_no_pop", 32'(popped - pm0), 0);
        chk("postrst_no_issue", 32'(issued - is0), 0);
        push_frame();
        iss_n = 0; pop_seq = 0;
        pulse_start();
        for (int i = 0; i < 2000 && pop_seq < 300; i++) tick();
        chk("f4_progress", 32'(pop_seq >= 300), 1);
        check_first_issues("f4_issue_addr");
        chk("f4_first_pixel", 32'(p0), 32'({8'h00, 1'b1, 1'b0, 1'b0}));

        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
